// File: rtl/rs_issue_scheduler_pkg.sv
// Shared constants, issue packet type and index-wrap helper for the RS issue scheduler.
package rs_issue_scheduler_pkg;

  localparam int RS_LEN_DEFAULT   = 16;
  localparam int RS_WAYS          = 3;
  localparam int MULT_LAT_DEFAULT = 4;
  localparam int RS_IDX_W         = $clog2(RS_LEN_DEFAULT);

  typedef logic [RS_IDX_W-1:0] rs_idx_t;

  typedef struct packed {
    logic    valid;
    rs_idx_t idx;
  } rs_sched_issue_packet_t;

  // Single-step modular wrap; callers never exceed 2*len-1.
  function automatic int unsigned wrap_idx(input int unsigned v, input int unsigned len);
    return (v >= len) ? (v - len) : v;
  endfunction

endpackage

// File: rtl/rs_issue_scheduler_picker.sv
// Rotating-priority picker: grants up to WAYS requests starting at start, at most one multiply.
module rs_rr_picker
  import rs_issue_scheduler_pkg::*;
#(
  parameter  int N    = RS_LEN_DEFAULT,
  parameter  int WAYS = RS_WAYS,
  localparam int IW   = $clog2(N),
  localparam int WC   = $clog2(WAYS + 1)
) (
  input  logic [N-1:0]             req,
  input  logic [IW-1:0]            start,
  input  logic [N-1:0]             is_mult,
  input  logic                     mult_ok,
  output logic [WAYS-1:0][N-1:0]   grant,
  output logic [WAYS-1:0]          grant_valid,
  output logic [WAYS-1:0][IW-1:0]  grant_idx,
  output logic [IW-1:0]            last_idx
);

  logic [WC-1:0] cnt;
  logic [IW-1:0] pos;
  logic          mult_taken;

  always_comb begin
    grant       = '0;
    grant_valid = '0;
    grant_idx   = '0;
    last_idx    = start;
    cnt         = '0;
    pos         = '0;
    mult_taken  = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = IW'(wrap_idx(32'(start) + 32'(k), 32'(N)));
      // A multiply is skipped (not stalling the search) when the unit is unavailable.
      if (req[pos] && (cnt < WC'(WAYS)) && !(is_mult[pos] && (!mult_ok || mult_taken))) begin
        grant[cnt][pos]  = 1'b1;
        grant_valid[cnt] = 1'b1;
        grant_idx[cnt]   = pos;
        last_idx         = pos;
        if (is_mult[pos]) mult_taken = 1'b1;
        cnt = cnt + WC'(1);
      end
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// RS line allocator, rotating-priority issue selector and multiplier arbiter.
// Define RS_SCHED_MULT_PIPE_EN for a fully pipelined multiplier (no busy counter).
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
#(
  parameter  int RS_LEN   = RS_LEN_DEFAULT,
  parameter  int WAYS     = RS_WAYS,
  parameter  int MULT_LAT = MULT_LAT_DEFAULT,
  localparam int IDX_W    = $clog2(RS_LEN)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic [1:0]                 dp_num,
  input  logic [RS_LEN-1:0]          line_busy,
  input  logic [RS_LEN-1:0]          line_ready,
  input  logic [RS_LEN-1:0]          line_is_mult,
  output logic [WAYS-1:0]            alloc_en,
  output logic [WAYS-1:0][IDX_W-1:0] alloc_idx,
  output logic                       dp_stall,
  output logic [WAYS-1:0]            issue_valid,
  output logic [WAYS-1:0][IDX_W-1:0] issue_idx,
  output logic [RS_LEN-1:0]          line_clear,
  output logic                       mult_busy
);

  localparam int FCW = $clog2(RS_LEN + 1);
  localparam int WC  = $clog2(WAYS + 1);

  logic [RS_LEN-1:0]          inflight_reg;
  logic [RS_LEN-1:0]          line_clear_reg;
  logic [WAYS-1:0]            issue_valid_reg;
  logic [WAYS-1:0][IDX_W-1:0] issue_idx_reg;
  logic [IDX_W-1:0]           rr_ptr_reg;
  logic [IDX_W-1:0]           rr_ptr_next;

  logic [RS_LEN-1:0]          free_mask;
  logic [FCW-1:0]             free_cnt;
  logic [WAYS-1:0][IDX_W-1:0] free_idx;
  logic [WC-1:0]              fill;
  logic                       alloc_ok;

  logic [RS_LEN-1:0]              cand;
  logic [WAYS-1:0][RS_LEN-1:0]    pick_grant;
  logic [WAYS-1:0]                pick_valid;
  logic [WAYS-1:0][IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]               pick_last;
  logic [RS_LEN-1:0]              grant_mask;
  logic                           mult_ok;

  // Allocation: lowest-index free lines, all-or-nothing against dp_num.
  assign free_mask = ~line_busy & ~inflight_reg;

  always_comb begin
    free_cnt = '0;
    free_idx = '0;
    fill     = '0;
    for (int i = 0; i < RS_LEN; i++) begin
      if (free_mask[i]) begin
        free_cnt = free_cnt + FCW'(1);
        if (fill < WC'(WAYS)) begin
          free_idx[fill] = IDX_W'(i);
          fill = fill + WC'(1);
        end
      end
    end
  end

  assign alloc_ok  = !squash && (dp_num != 2'd0) && (free_cnt >= FCW'(dp_num));
  assign dp_stall  = !squash && (dp_num != 2'd0) && (free_cnt <  FCW'(dp_num));
  assign alloc_idx = free_idx;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_alloc_en
    assign alloc_en[gi] = alloc_ok && (2'(gi) < dp_num);
  end

  // Lines granted last cycle or being cleared are excluded from selection.
  assign cand = line_busy & line_ready & ~inflight_reg & ~line_clear_reg;

  rs_rr_picker #(
    .N    (RS_LEN),
    .WAYS (WAYS)
  ) u_picker (
    .req         (cand),
    .start       (rr_ptr_reg),
    .is_mult     (line_is_mult),
    .mult_ok     (mult_ok),
    .grant       (pick_grant),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx),
    .last_idx    (pick_last)
  );

  always_comb begin
    grant_mask = '0;
    for (int w = 0; w < WAYS; w++) grant_mask = grant_mask | pick_grant[w];
  end

  assign rr_ptr_next = IDX_W'(wrap_idx(32'(pick_last) + 32'd1, 32'(RS_LEN)));

`ifdef RS_SCHED_MULT_PIPE_EN
  assign mult_ok   = 1'b1;
  assign mult_busy = 1'b0;
`else
  localparam int CW = $clog2(MULT_LAT);

  logic [CW-1:0] mult_cnt_reg;
  logic          mult_grant;

  assign mult_grant = |(grant_mask & line_is_mult);

  // Squash does not stop an in-flight multiply; it just drains.
  always_ff @(posedge clock) begin
    if (reset) begin
      mult_cnt_reg <= '0;
    end else if (!squash && mult_grant) begin
      mult_cnt_reg <= CW'(MULT_LAT - 1);
    end else if (mult_cnt_reg != '0) begin
      mult_cnt_reg <= mult_cnt_reg - CW'(1);
    end
  end

  assign mult_busy = (mult_cnt_reg != '0);
  assign mult_ok   = !mult_busy;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_valid_reg <= '0;
      issue_idx_reg   <= '0;
      line_clear_reg  <= '1;
      inflight_reg    <= '0;
      rr_ptr_reg      <= '0;
    end else if (squash) begin
      issue_valid_reg <= '0;
      line_clear_reg  <= '1;
      inflight_reg    <= '0;
    end else begin
      issue_valid_reg <= pick_valid;
      issue_idx_reg   <= pick_idx;
      line_clear_reg  <= grant_mask;
      inflight_reg    <= grant_mask;
      if (|pick_valid) rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign issue_valid = issue_valid_reg;
  assign issue_idx   = issue_idx_reg;
  assign line_clear  = line_clear_reg;

endmodule
